bpred_ctrl: RTL and testbench

BPRED_CTRL -- requirements
Module: bpred_ctrl

---
 rtl/bpred_ctrl.sv | 137 +++++++++++++
 tb/tb_bpred_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bpred_ctrl.sv
// Branch predictor controller: a table of ENTRIES 2-bit saturating counters
// with a registered lookup port, a resolution update port, a two-state
// (INIT/RUN) controller that walks the table to "strongly taken" after reset
// or flush, and a saturating misprediction counter.
module bpred_ctrl #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             lk_vld,
    input  logic [31:0]      lk_pc,
    output logic             lk_rdy,
    output logic             pred_vld,
    output logic             pred_take,
    output logic [IDX_W-1:0] pred_idx,
    input  logic             upd_vld,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    input  logic             upd_pred,
    output logic             upd_rdy,
    output logic             init_busy,
    output logic [15:0]      mispred_cnt
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_init_idx;
    logic [1:0]       r_cnt [ENTRIES];

    logic             r_pred_vld;
    logic             r_pred_take;
    logic [IDX_W-1:0] r_pred_idx;
    logic [15:0]      r_mispred_cnt;

    logic             w_run;
    logic             w_lk_acc;
    logic             w_upd_acc;
    logic [IDX_W-1:0] w_lk_idx;
    logic [1:0]       w_upd_new;
    logic [1:0]       w_lk_cnt;
    logic             w_init_last;
    logic             w_unused_pc;

    // Saturating 2-bit counter step toward the resolved outcome.
    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic taken);
        logic [1:0] r;
        r = c;
        if (taken) begin
            if (c != 2'b11) r = c + 2'd1;
        end else begin
            if (c != 2'b00) r = c - 2'd1;
        end
        return r;
    endfunction

    assign w_lk_idx    = lk_pc[IDX_W+1:2];
    assign w_unused_pc = ^{lk_pc[31:IDX_W+2], lk_pc[1:0]};
    assign w_lk_acc    = lk_vld & lk_rdy;
    assign w_upd_acc   = upd_vld & upd_rdy;
    assign w_upd_new   = sat_step(r_cnt[upd_idx], upd_taken);
    assign w_init_last = (r_init_idx == IDX_W'(ENTRIES - 1));

    // Same-cycle update to the looked-up entry is forwarded so the
    // prediction reflects the post-update counter.
    assign w_lk_cnt = (w_upd_acc && (upd_idx == w_lk_idx)) ? w_upd_new : r_cnt[w_lk_idx];

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_INIT;
        else        r_state <= w_state_nxt;
    end

    // Next-state and handshake/status outputs; flush always returns to INIT.
    always_comb begin
        w_state_nxt = r_state;
        w_run       = (r_state == ST_RUN);
        init_busy   = (r_state == ST_INIT);
        lk_rdy      = w_run & ~flush;
        upd_rdy     = w_run & ~flush;
        case (r_state)
            ST_INIT: if (!flush && w_init_last) w_state_nxt = ST_RUN;
            ST_RUN:  if (flush) w_state_nxt = ST_INIT;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Initialization walk index; restarts at 0 on any flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   r_init_idx <= '0;
        else if (flush)               r_init_idx <= '0;
        else if (r_state == ST_INIT)  r_init_idx <= w_init_last ? '0 : r_init_idx + 1'b1;
    end

    // Counter table: single write port shared by the init walk and updates.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT)  r_cnt[r_init_idx] <= 2'b11;
        else if (w_upd_acc)      r_cnt[upd_idx]    <= w_upd_new;
    end

    // Registered prediction; index and direction hold when no lookup is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pred_vld  <= 1'b0;
            r_pred_take <= 1'b0;
            r_pred_idx  <= '0;
        end else begin
            r_pred_vld <= w_lk_acc;
            if (w_lk_acc) begin
                r_pred_take <= w_lk_cnt[1];
                r_pred_idx  <= w_lk_idx;
            end
        end
    end

    // Misprediction counter, saturating at all-ones, cleared by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_mispred_cnt <= '0;
        else if (flush)
            r_mispred_cnt <= '0;
        else if (w_upd_acc && (upd_taken != upd_pred) && (r_mispred_cnt != 16'hFFFF))
            r_mispred_cnt <= r_mispred_cnt + 16'd1;
    end

    assign pred_vld    = r_pred_vld;
    assign pred_take   = r_pred_take;
    assign pred_idx    = r_pred_idx;
    assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_bpred_ctrl.sv
// Testbench for bpred_ctrl: directed stimulus with hand-computed predictions
// queued as they are issued; a monitor pops and compares on each pred_vld.
module tb_bpred_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        lk_vld = 1'b0;
    logic [31:0] lk_pc = '0;
    logic        lk_rdy;
    logic        pred_vld;
    logic        pred_take;
    logic [3:0]  pred_idx;
    logic        upd_vld = 1'b0;
    logic [3:0]  upd_idx = '0;
    logic        upd_taken = 1'b0;
    logic        upd_pred = 1'b0;
    logic        upd_rdy;
    logic        init_busy;
    logic [15:0] mispred_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       take;
        logic [3:0] idx;
    } exp_t;
    exp_t exp_q[$];

    bpred_ctrl #(.ENTRIES(16), .IDX_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .lk_vld(lk_vld), .lk_pc(lk_pc), .lk_rdy(lk_rdy),
        .pred_vld(pred_vld), .pred_take(pred_take), .pred_idx(pred_idx),
        .upd_vld(upd_vld), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_pred(upd_pred), .upd_rdy(upd_rdy),
        .init_busy(init_busy), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented prediction must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && pred_vld === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pred_vld", 32'(pred_vld), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pred_idx", 32'(pred_idx), 32'(e.idx));
                    check("pred_take", 32'(pred_take), 32'(e.take));
                end
            end
        end
    end

    // One cycle of stimulus, issued at a negedge and removed at the next.
    task automatic cyc(input logic lv, input logic [31:0] pc, input logic uv,
                       input logic [3:0] ui, input logic ut, input logic up);
        lk_vld = lv; lk_pc = pc;
        upd_vld = uv; upd_idx = ui; upd_taken = ut; upd_pred = up;
        @(negedge clk);
        lk_vld = 1'b0; upd_vld = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc, input logic take);
        exp_t e;
        e.take = take;
        e.idx  = pc[5:2];
        exp_q.push_back(e);
        cyc(1'b1, pc, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic upd(input logic [3:0] idx, input logic taken, input logic pred);
        cyc(1'b0, 32'd0, 1'b1, idx, taken, pred);
    endtask

    // Counts negedge samples with init_busy high, starting at the current one.
    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (init_busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check(name, 32'(n), 32'd16);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_init_busy"}, 32'(init_busy), 32'd1);
        check({tag, "_lk_rdy"}, 32'(lk_rdy), 32'd0);
        check({tag, "_upd_rdy"}, 32'(upd_rdy), 32'd0);
        check({tag, "_pred_vld"}, 32'(pred_vld), 32'd0);
        check({tag, "_pred_take"}, 32'(pred_take), 32'd0);
        check({tag, "_pred_idx"}, 32'(pred_idx), 32'd0);
        check({tag, "_mispred"}, 32'(mispred_cnt), 32'd0);
    endtask

    initial begin
        // Reset held over a few edges, with control inputs asserted and ignored.
        flush = 1'b1; lk_vld = 1'b1; upd_vld = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        flush = 1'b0; lk_vld = 1'b0; upd_vld = 1'b0;
        rst_n = 1'b1;
        wait_init("init_len_after_reset");
        check("run_lk_rdy", 32'(lk_rdy), 32'd1);

        // Fresh table predicts taken.
        look(32'h0000_0014, 1'b1);
        cyc(1'b0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        check("idle_pred_vld", 32'(pred_vld), 32'd0);
        check("hold_pred_idx", 32'(pred_idx), 32'd5);
        check("hold_pred_take", 32'(pred_take), 32'd1);

        // Idx 3: N,N,N,T -> counters 10,01,00,01.
        upd(4'd3, 1'b0, 1'b0); look(32'h0000_000C, 1'b1);
        upd(4'd3, 1'b0, 1'b0); look(32'h0000_000C, 1'b0);
        upd(4'd3, 1'b0, 1'b0); look(32'h0000_000C, 1'b0);
        upd(4'd3, 1'b1, 1'b1); look(32'h0000_000C, 1'b0);

        // Same-cycle lookup and update to idx 2: 11->10 (take 1), 10->01 (take 0).
        begin
            exp_t e;
            e.idx = 4'd2; e.take = 1'b1; exp_q.push_back(e);
            cyc(1'b1, 32'h0000_0008, 1'b1, 4'd2, 1'b0, 1'b0);
            e.take = 1'b0; exp_q.push_back(e);
            cyc(1'b1, 32'h0000_0008, 1'b1, 4'd2, 1'b0, 1'b0);
            // Different indices: lookup idx 5 (11), update idx 3 taken (01->10).
            e.idx = 4'd5; e.take = 1'b1; exp_q.push_back(e);
            cyc(1'b1, 32'h0000_0014, 1'b1, 4'd3, 1'b1, 1'b1);
        end
        look(32'h0000_000C, 1'b1);
        check("mispred_zero", 32'(mispred_cnt), 32'd0);

        // Three mispredictions then a correct one.
        upd(4'd7, 1'b1, 1'b0);
        upd(4'd7, 1'b1, 1'b0);
        upd(4'd7, 1'b0, 1'b1);
        upd(4'd7, 1'b1, 1'b1);
        check("mispred_three", 32'(mispred_cnt), 32'd3);

        // Drive the counter to saturation with back-to-back mispredictions.
        upd_idx = 4'd7; upd_taken = 1'b1; upd_pred = 1'b0; upd_vld = 1'b1;
        repeat (65531) @(negedge clk);
        upd_vld = 1'b0;
        check("mispred_fffe", 32'(mispred_cnt), 32'h0000_FFFE);
        upd(4'd7, 1'b1, 1'b0);
        check("mispred_ffff", 32'(mispred_cnt), 32'h0000_FFFF);
        upd(4'd7, 1'b0, 1'b1);
        check("mispred_sat", 32'(mispred_cnt), 32'h0000_FFFF);

        // Flush in RUN with a lookup pending: not accepted, table reinitialized.
        flush = 1'b1; lk_vld = 1'b1; lk_pc = 32'h0000_000C;
        upd_vld = 1'b1; upd_idx = 4'd3; upd_taken = 1'b0; upd_pred = 1'b1;
        #1;
        check("flush_lk_rdy", 32'(lk_rdy), 32'd0);
        check("flush_upd_rdy", 32'(upd_rdy), 32'd0);
        @(negedge clk);
        flush = 1'b0; lk_vld = 1'b0; upd_vld = 1'b0;
        check("flush_pred_vld", 32'(pred_vld), 32'd0);
        check("flush_mispred", 32'(mispred_cnt), 32'd0);
        wait_init("init_len_after_flush");
        for (int i = 0; i < 16; i++) look(32'(i * 4), 1'b1);

        // Flush in INIT restarts the walk.
        cyc(1'b0, 32'd0, 1'b1, 4'd9, 1'b0, 1'b1);
        check("mispred_before_flush", 32'(mispred_cnt), 32'd1);
        flush = 1'b1; @(negedge clk); flush = 1'b0;
        repeat (5) @(negedge clk);
        flush = 1'b1; @(negedge clk); flush = 1'b0;
        check("init_flush_mispred", 32'(mispred_cnt), 32'd0);
        wait_init("init_len_after_init_flush");
        look(32'h0000_0024, 1'b1);

        // Asynchronous reset in INIT cycle 7.
        flush = 1'b1; @(negedge clk); flush = 1'b0;
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("init_len_after_mid_reset");
        for (int i = 0; i < 16; i++) look(32'(i * 4), 1'b1);

        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
